// File: rtl/denormalize_if.sv
// Stream-in / accumulator-out bundle for the fp32 denormalizer.
// Carries special_cnt only when DENORMALIZE_SPECIAL_CNT_EN is defined.
interface denormalize_if;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        outr;
  logic        signo;
  logic [9:0]  expo;
  logic [31:0] addo;
  logic        busy;
  logic        done;
`ifdef DENORMALIZE_SPECIAL_CNT_EN
  logic [7:0]  special_cnt;

  modport master (
    output start, s_valid, s_data,
    input  s_ready, outr, signo, expo, addo, busy, done, special_cnt
  );
  modport slave (
    input  start, s_valid, s_data,
    output s_ready, outr, signo, expo, addo, busy, done, special_cnt
  );
`else
  modport master (
    output start, s_valid, s_data,
    input  s_ready, outr, signo, expo, addo, busy, done
  );
  modport slave (
    input  start, s_valid, s_data,
    output s_ready, outr, signo, expo, addo, busy, done
  );
`endif
endinterface

// File: rtl/denormalize.sv
// Converts a sequence of LEN fp32 words into accumulator (sign, exponent, mantissa) form.
// Optional special-value counter enabled by DENORMALIZE_SPECIAL_CNT_EN.
module denormalize #(
  parameter int unsigned LEN = 16
) (
  input logic          clk,
  input logic          rst_n,
  denormalize_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StLast} state_t;

  localparam logic [8:0] LastIdx = 9'(LEN - 1);

  state_t      r_state, w_state_d;
  logic [8:0]  r_cnt, w_cnt_d;
  logic        w_accept;
  logic [7:0]  w_exp;
  logic        w_signo;
  logic [9:0]  w_expo;
  logic [31:0] w_addo;

  logic        r_outr;
  logic        r_signo;
  logic [9:0]  r_expo;
  logic [31:0] r_addo;

  assign w_accept = (r_state == StLoad) && bus.s_valid;
  assign w_exp    = bus.s_data[30:23];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = StLoad;
          w_cnt_d   = '0;
        end
      end
      StLoad: begin
        if (w_accept) begin
          if (r_cnt == LastIdx) begin
            w_state_d = StLast;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 9'd1;
          end
        end
      end
      StLast: begin
        // A start coinciding with done chains straight into the next sequence.
        w_state_d = bus.start ? StLoad : StIdle;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    w_signo = 1'b0;
    w_expo  = '0;
    w_addo  = '0;
    if (w_exp == 8'hFF) begin
      w_signo = bus.s_data[31];
      w_expo  = 10'd365;
      w_addo  = 32'h7FFF_FF80;
    end else if (w_exp != 8'h00) begin
      w_signo = bus.s_data[31];
      w_expo  = {2'b00, w_exp} + 10'd111;
      w_addo  = {1'b0, 1'b1, bus.s_data[22:0], 7'b0};
    end
  end

  // Outputs hold their last converted word while no word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outr  <= 1'b0;
      r_signo <= 1'b0;
      r_expo  <= '0;
      r_addo  <= '0;
    end else begin
      r_outr <= w_accept;
      if (w_accept) begin
        r_signo <= w_signo;
        r_expo  <= w_expo;
        r_addo  <= w_addo;
      end
    end
  end

  assign bus.s_ready = (r_state == StLoad);
  assign bus.busy    = (r_state != StIdle);
  assign bus.done    = (r_state == StLast);
  assign bus.outr    = r_outr;
  assign bus.signo   = r_signo;
  assign bus.expo    = r_expo;
  assign bus.addo    = r_addo;

`ifdef DENORMALIZE_SPECIAL_CNT_EN
  logic       w_special;
  logic [7:0] r_special_cnt;

  assign w_special = (w_exp == 8'h00) || (w_exp == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_special_cnt <= '0;
    end else if ((r_state == StIdle) && bus.start) begin
      r_special_cnt <= '0;
    end else if (w_accept && w_special && (r_special_cnt != 8'hFF)) begin
      r_special_cnt <= r_special_cnt + 8'd1;
    end
  end

  assign bus.special_cnt = r_special_cnt;
`endif

endmodule

// File: tb/tb_denormalize.sv
// Self-checking bench for denormalize: vector table, corner sequences and random traffic
// against a word-level reference model.
module tb_denormalize;

  localparam int unsigned LEN = 4;

  typedef struct {
    logic [31:0] data;
    logic        sig;
    logic [9:0]  expo;
    logic [31:0] addo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  denormalize_if bus ();
  denormalize_if bus1 ();

  denormalize #(.LEN(LEN)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  denormalize #(.LEN(1))   dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: words still owed in the current sequence plus the last converted word.
  bit          m_load, m_last, m_outr, m_sig;
  int          m_left;
  logic [9:0]  m_expo;
  logic [31:0] m_addo;
  logic [31:0] m_word;
  int          m_spec;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void ref_conv(input logic [31:0] w, output bit s, output logic [9:0] e,
                                   output logic [31:0] a);
    int     ex;
    longint mag;
    ex = int'(w[30:23]);
    if (ex == 0) begin
      s = 0; e = 0; a = 0;
    end else if (ex == 255) begin
      s = w[31]; e = 10'd365; a = 32'h7FFF_FF80;
    end else begin
      // value = 1.m * 2^(ex-127) = addo * 2^(expo-268)
      mag = (longint'(1) << 23) + longint'(w[22:0]);
      mag = mag * 128;
      s = w[31];
      e = 10'(ex + 111);
      a = mag[31:0];
    end
  endfunction

  // Accumulator normalizer: rebuilds an fp32 word from (sign, expo, addo).
  function automatic logic [31:0] normalize(input logic s, input logic [9:0] e,
                                            input logic [31:0] a);
    int          p;
    int          be;
    logic [31:0] man;
    if (a == 32'h0) return 32'h0;
    if (e == 10'd365 && a == 32'h7FFF_FF80) return {s, 8'hFF, 23'h0};
    p = 31;
    while (p > 0 && !a[p]) p--;
    be  = p + int'(e) - 268 + 127;
    man = (p >= 23) ? (a >> (p - 23)) : (a << (23 - p));
    return {s, be[7:0], man[22:0]};
  endfunction

  function automatic bit is_normal(input logic [31:0] w);
    return (w[30:23] != 8'h00) && (w[30:23] != 8'hFF);
  endfunction

  function automatic logic [31:0] rand_word();
    int          k;
    logic [31:0] w;
    k = $urandom_range(0, 7);
    w = $urandom;
    if (k == 0) w[30:23] = 8'h00;
    else if (k == 1) w[30:23] = 8'hFF;
    else w[30:23] = 8'($urandom_range(1, 254));
    return w;
  endfunction

  function automatic void model_clear();
    m_load = 0; m_last = 0; m_outr = 0; m_sig = 0; m_left = 0;
    m_expo = 0; m_addo = 0; m_word = 0; m_spec = 0;
  endfunction

  function automatic void check_all();
    chk("s_ready", 32'(bus.s_ready), 32'(m_load));
    chk("busy", 32'(bus.busy), 32'(m_load | m_last));
    chk("done", 32'(bus.done), 32'(m_last));
    chk("outr", 32'(bus.outr), 32'(m_outr));
    chk("signo", 32'(bus.signo), 32'(m_sig));
    chk("expo", 32'(bus.expo), 32'(m_expo));
    chk("addo", bus.addo, m_addo);
`ifdef DENORMALIZE_SPECIAL_CNT_EN
    chk("special_cnt", 32'(bus.special_cnt), 32'(m_spec));
`endif
    if (m_outr && is_normal(m_word))
      chk("roundtrip", normalize(bus.signo, bus.expo, bus.addo), m_word);
  endfunction

  function automatic void check_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_outr"}, 32'(bus.outr), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_signo"}, 32'(bus.signo), 0);
    chk({tag, "_expo"}, 32'(bus.expo), 0);
    chk({tag, "_addo"}, bus.addo, 0);
`ifdef DENORMALIZE_SPECIAL_CNT_EN
    chk({tag, "_special_cnt"}, 32'(bus.special_cnt), 0);
`endif
  endfunction

  // One clock of stimulus, then advance the model and compare.
  task automatic step(input bit st, input bit v, input logic [31:0] d);
    bit acc;
    bus.start   = st;
    bus.s_valid = v;
    bus.s_data  = d;
    @(posedge clk);
    #1;
    acc    = m_load && v;
    m_outr = acc;
    if (acc) begin
      ref_conv(d, m_sig, m_expo, m_addo);
      m_word = d;
      if (!is_normal(d) && m_spec < 255) m_spec++;
    end
    if (m_load) begin
      if (acc) begin
        m_left--;
        if (m_left == 0) begin
          m_load = 0;
          m_last = 1;
        end
      end
    end else if (m_last) begin
      m_last = 0;
      if (st) begin
        m_load = 1; m_left = LEN;
      end
    end else if (st) begin
      m_load = 1; m_left = LEN; m_spec = 0;
    end
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[4];
    int   pulses;
    int   sent;
    bit   tv[6];

    tbl[0] = '{32'h3F80_0000, 1'b0, 10'd238, 32'h4000_0000};
    tbl[1] = '{32'hC020_0000, 1'b1, 10'd239, 32'h5000_0000};
    tbl[2] = '{32'h0000_0000, 1'b0, 10'd0,   32'h0000_0000};
    tbl[3] = '{32'h7F80_0000, 1'b0, 10'd365, 32'h7FFF_FF80};

    bus.start = 0; bus.s_valid = 0; bus.s_data = 0;
    bus1.start = 0; bus1.s_valid = 0; bus1.s_data = 0;
    model_clear();
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: one full sequence of LEN=4 words.
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, tbl[i].data);
      chk("tbl_signo", 32'(bus.signo), 32'(tbl[i].sig));
      chk("tbl_expo", 32'(bus.expo), 32'(tbl[i].expo));
      chk("tbl_addo", bus.addo, tbl[i].addo);
      chk("tbl_done", 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
    end
    step(0, 0, 0);

    // Gappy s_valid: 1,0,1,0,1,1 then a valid word after done must not be taken.
    tv = '{1, 0, 1, 0, 1, 1};
    pulses = 0;
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, tv[i], rand_word());
      if (bus.outr) pulses++;
    end
    chk("gap_done", 32'(bus.done), 1);
    step(0, 1, rand_word());
    if (bus.outr) pulses++;
    chk("gap_pulses", 32'(pulses), 4);
    chk("gap_ready_after", 32'(bus.s_ready), 0);
    chk("gap_busy_after", 32'(bus.busy), 0);

    // start mid-LOAD is ignored; start in the done cycle chains a new sequence.
    step(1, 0, 0);
    step(0, 1, rand_word());
    step(0, 1, rand_word());
    step(1, 1, rand_word());
    step(0, 1, rand_word());
    chk("midstart_done", 32'(bus.done), 1);
    step(1, 0, 0);
    chk("chain_ready", 32'(bus.s_ready), 1);
    for (int i = 0; i < 4; i++) step(0, 1, rand_word());
    step(0, 0, 0);

    // Reset after word 2 of 4 discards the sequence.
    step(1, 0, 0);
    step(0, 1, rand_word());
    step(0, 1, rand_word());
    do_reset("midrst");
    for (int i = 0; i < 3; i++) step(0, 1, rand_word());
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, rand_word());
    step(0, 0, 0);

    // LEN=1 instance: IDLE->LOAD->LAST->IDLE on one word.
    bus1.start = 1;
    @(posedge clk); #1;
    bus1.start = 0;
    chk("len1_ready", 32'(bus1.s_ready), 1);
    chk("len1_busy", 32'(bus1.busy), 1);
    bus1.s_valid = 1; bus1.s_data = 32'hC020_0000;
    @(posedge clk); #1;
    bus1.s_valid = 0;
    chk("len1_outr", 32'(bus1.outr), 1);
    chk("len1_done", 32'(bus1.done), 1);
    chk("len1_expo", 32'(bus1.expo), 239);
    chk("len1_addo", bus1.addo, 32'h5000_0000);
    @(posedge clk); #1;
    chk("len1_idle_busy", 32'(bus1.busy), 0);
    chk("len1_idle_outr", 32'(bus1.outr), 0);

    // Random traffic, including starts while busy.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, rand_word());

`ifdef DENORMALIZE_SPECIAL_CNT_EN
    // 300 NaN words across chained sequences saturate the special counter.
    do_reset("specrst");
    sent = 0;
    step(1, 0, 0);
    while (sent < 300) begin
      if (m_last) step(1, 0, 0);
      else begin
        step(0, 1, 32'h7FC0_0000);
        sent++;
      end
    end
    chk("special_sat", 32'(bus.special_cnt), 255);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("special_clear", 32'(bus.special_cnt), 0);
`else
    sent = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
